// File: rtl/game_clock_pkg.sv
// rtl/game_clock_pkg.sv - shared state encoding and counter widths for the game clock
package game_clock_pkg;

  localparam int SEC_W = 10;
  localparam int SUB_W = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/tick_sync_edge.sv
// rtl/tick_sync_edge.sv - synchronises the divided clock and emits one tick per rising edge
module tick_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic in_clk,
  input  logic rst_n,
  input  logic div_clk_in,
  output logic tick
);

  localparam int PRIME_CYCLES = SYNC_STAGES + 1;
  localparam int PRIME_W      = $clog2(PRIME_CYCLES + 1);
  localparam logic [PRIME_W-1:0] PRIME_DONE = PRIME_W'(PRIME_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   tick_q, tick_d;
  logic [PRIME_W-1:0]     prime_q, prime_d;
  logic                   primed;
  logic                   sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign primed   = (prime_q == PRIME_DONE);

  // Until the chain has flushed its reset zeros, a high input would look like an edge.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], div_clk_in};
    prev_d  = sync_out;
    prime_d = primed ? prime_q : prime_q + PRIME_W'(1);
    tick_d  = sync_out & ~prev_q & primed;
  end

  always_ff @(posedge in_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      tick_q  <= 1'b0;
      prime_q <= '0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      tick_q  <= tick_d;
      prime_q <= prime_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/game_clock_timer.sv
// rtl/game_clock_timer.sv - hockey period countdown (seconds + hundredths) with start/pause/clear
// Optional low-time warning output enabled by defining GAME_CLOCK_WARN_EN.
module game_clock_timer
  import game_clock_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int TICKS_PER_SEC = 100,
  parameter int PERIOD_SEC    = 300,
  parameter int WARN_SEC      = 10
) (
  input  logic             in_clk,
  input  logic             rst_n,
  input  logic             div_clk_in,
  input  logic             start,
  input  logic             pause,
  input  logic             clear,
  output logic             tick,
  output logic [SEC_W-1:0] sec_left,
  output logic [SUB_W-1:0] sub_left,
  output logic             running,
  output logic             expired,
  output logic             warn
);

  localparam logic [SEC_W-1:0] SEC_LOAD = SEC_W'(PERIOD_SEC);
  localparam logic [SUB_W-1:0] SUB_TOP  = SUB_W'(TICKS_PER_SEC - 1);

  if (SYNC_STAGES < 2 || PERIOD_SEC < 0 || PERIOD_SEC > 1023 || TICKS_PER_SEC < 1 ||
      TICKS_PER_SEC > 128 || WARN_SEC < 0 || WARN_SEC > 1023) begin : g_bad_param
    $error("game_clock_timer: parameter out of range");
  end

  state_e           state_q, state_d;
  logic [SEC_W-1:0] sec_q, sec_d;
  logic [SUB_W-1:0] sub_q, sub_d;
  logic             running_q, running_d;
  logic             expired_q, expired_d;
  logic             tick_w;

  tick_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_tick (
    .in_clk     (in_clk),
    .rst_n      (rst_n),
    .div_clk_in (div_clk_in),
    .tick       (tick_w)
  );

  always_ff @(posedge in_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sec_q     <= SEC_LOAD;
      sub_q     <= '0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sec_q     <= sec_d;
      sub_q     <= sub_d;
      running_q <= running_d;
      expired_q <= expired_d;
    end
  end

  // clear beats pause beats start; a tick only counts in RUN when neither pause nor clear is up.
  always_comb begin
    state_d = state_q;
    sec_d   = sec_q;
    sub_d   = sub_q;
    if (clear) begin
      state_d = IDLE;
      sec_d   = SEC_LOAD;
      sub_d   = '0;
    end else begin
      unique case (state_q)
        IDLE, PAUSE: begin
          if (start && !pause) state_d = RUN;
        end
        RUN: begin
          if (pause) begin
            state_d = PAUSE;
          end else if (tick_w) begin
            if (sub_q != '0) begin
              sub_d = sub_q - 1'b1;
            end else if (sec_q != '0) begin
              sec_d = sec_q - 1'b1;
              sub_d = SUB_TOP;
            end
            if (sub_d == '0 && sec_d == '0) state_d = DONE;
          end
        end
        DONE: begin
          state_d = DONE;
        end
      endcase
    end
    running_d = !clear && (state_q == RUN);
    expired_d = !clear && (state_q == DONE);
  end

`ifdef GAME_CLOCK_WARN_EN
  localparam logic [SEC_W-1:0] WARN_LIM = SEC_W'(WARN_SEC);

  logic warn_q, warn_d;

  always_comb begin
    warn_d = !clear && (state_q == RUN || state_q == PAUSE) && (sec_q < WARN_LIM);
  end

  always_ff @(posedge in_clk or negedge rst_n) begin
    if (!rst_n) warn_q <= 1'b0;
    else        warn_q <= warn_d;
  end

  assign warn = warn_q;
`else
  assign warn = 1'b0;
`endif

  assign tick     = tick_w;
  assign sec_left = sec_q;
  assign sub_left = sub_q;
  assign running  = running_q;
  assign expired  = expired_q;

endmodule
